// File: rtl/dlx_hazard_ctrl.sv
// dlx_hazard_ctrl: hazard and sequencing controller for the 5-stage DLX pipeline.
// Generates the load-use interlock (LOAD_WAIT stall cycles), the branch flush
// sequence (FLUSH_CYCLES) and the EX-stage operand forwarding selects.
// Optional performance counters are built only when DLX_HAZ_PERF_CNT_EN is defined;
// otherwise stall_cnt/flush_cnt are tied to zero.
`timescale 1ns/1ps

module dlx_hazard_ctrl #(
  parameter int unsigned LOAD_WAIT    = 1,      // 1..7
  parameter int unsigned FLUSH_CYCLES = 2,      // 1..3
  parameter logic [5:0]  OP_LW        = 6'h23,
  parameter logic [5:0]  OP_SW        = 6'h2B,
  parameter logic [5:0]  OP_BEQZ      = 6'h04,
  parameter logic [5:0]  OP_BNEZ      = 6'h05
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir_id,
  input  logic [31:0] ir_ex,
  input  logic [31:0] ir_mem,
  input  logic [31:0] ir_wb,
  input  logic        branch_en,
  output logic        stall_if,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        busy,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [5:0] OP_RTYPE     = 6'h00;
  localparam logic [5:0] OP_J         = 6'h02;
  localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_WAIT - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  localparam logic [1:0] SEL_REGFILE  = 2'b00;
  localparam logic [1:0] SEL_EXMEM    = 2'b01;
  localparam logic [1:0] SEL_MEMWB    = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  // Destination register written by an instruction; 0 means "writes nothing",
  // which also makes r0 destinations invisible to every comparison below.
  function automatic logic [4:0] dest_of(input logic [31:0] ir);
    logic [5:0] op;
    op = ir[31:26];
    if (ir == 32'h0 || op == OP_SW || op == OP_BEQZ || op == OP_BNEZ || op == OP_J)
      dest_of = 5'd0;
    else if (op == OP_RTYPE)
      dest_of = ir[15:11];
    else
      dest_of = ir[20:16];
  endfunction

  function automatic logic uses_rs1(input logic [5:0] op);
    uses_rs1 = (op != OP_J);
  endfunction

  function automatic logic uses_rs2(input logic [5:0] op);
    uses_rs2 = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQZ) || (op == OP_BNEZ);
  endfunction

  logic [4:0]      ex_dest, mem_dest, wb_dest;
  logic            ex_is_load, mem_is_load, load_use;
  logic [1:0]      lu_hit;
  logic [1:0][1:0] fwd_sel;
  logic            unused_id_bits;

  assign ex_dest        = dest_of(ir_ex);
  assign mem_dest       = dest_of(ir_mem);
  assign wb_dest        = dest_of(ir_wb);
  assign ex_is_load     = (ir_ex[31:26] == OP_LW);
  assign mem_is_load    = (ir_mem[31:26] == OP_LW);
  assign unused_id_bits = &{1'b0, ir_id[15:0]};

  // Per-operand source decode: operand 0 is rs1 [25:21], operand 1 is rs2 [20:16].
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [4:0] id_src;
      logic [4:0] ex_src;
      logic       id_use;
      logic       ex_use;
      logic [1:0] sel;

      if (gi == 0) begin : g_rs1
        assign id_src = ir_id[25:21];
        assign ex_src = ir_ex[25:21];
        assign id_use = uses_rs1(ir_id[31:26]);
        assign ex_use = uses_rs1(ir_ex[31:26]);
      end else begin : g_rs2
        assign id_src = ir_id[20:16];
        assign ex_src = ir_ex[20:16];
        assign id_use = uses_rs2(ir_id[31:26]);
        assign ex_use = uses_rs2(ir_ex[31:26]);
      end

      // Load-use candidate: this ID operand reads the register the EX load writes.
      assign lu_hit[gi] = id_use && (ex_dest != 5'd0) && (id_src == ex_dest);

      // Forwarding select: youngest producer (EX/MEM) wins, except a load whose
      // data is not ready until it reaches MEM/WB.
      always_comb begin
        sel = SEL_REGFILE;
        if (ex_use && (ex_src != 5'd0)) begin
          if (!mem_is_load && (mem_dest == ex_src))
            sel = SEL_EXMEM;
          else if (wb_dest == ex_src)
            sel = SEL_MEMWB;
        end
      end

      assign fwd_sel[gi] = sel;
    end
  endgenerate

  assign load_use = ex_is_load && (|lu_hit);
  assign fwd_a    = fwd_sel[0];
  assign fwd_b    = fwd_sel[1];

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  // Next-state and pipeline-control decode; branch takes priority over load-use in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_if  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (branch_en) begin
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (load_use) begin
          stall_if  = 1'b1;
          bubble_ex = 1'b1;
          if (LOAD_WAIT > 1) begin
            state_d = ST_LSTALL;
            cnt_d   = LOAD_RELOAD;
          end
        end
      end
      ST_LSTALL: begin
        // EX holds a bubble here, so a branch_en cannot be genuine and is ignored.
        stall_if  = 1'b1;
        bubble_ex = 1'b1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_FLUSH: begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
        if (branch_en) begin
          cnt_d = FLUSH_RELOAD;
        end else if (cnt_q <= 3'd1) begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State and wait-counter registers; reset aborts any stall or flush sequence.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != ST_RUN);

`ifdef DLX_HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters for stall and flush cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_if && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_id && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt_q <= 16'h0;
      flush_cnt_q <= 16'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'h0;
  assign flush_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// Testbench for dlx_hazard_ctrl: two instances (LOAD_WAIT=1 and LOAD_WAIT=3) share
// the instruction-register inputs; per-cycle expectations are queued when stimulus
// is driven and popped when the outputs are sampled mid-cycle.
`timescale 1ns/1ps

module tb_dlx_hazard_ctrl;

  typedef struct packed {
    logic       stall;
    logic       bubble;
    logic       flush;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
    logic       stall3;
    logic       bubble3;
    logic       flush3;
    logic       busy3;
  } obs_t;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] ex;
    logic [31:0] mem;
    logic [31:0] wb;
    logic        br;
    logic        rst;
    obs_t        e;
  } stim_t;

  localparam logic [31:0] NOP     = 32'h0;
  localparam logic [31:0] LW_R3   = 32'h8C230000;  // LW r3,0(r1)
  localparam logic [31:0] ADD_435 = 32'h00652020;  // ADD r4,r3,r5

  logic        clock;
  logic        reset;
  logic [31:0] ir_id, ir_ex, ir_mem, ir_wb;
  logic        branch_en;

  logic        stall_if, bubble_ex, flush_id, busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        stall_if3, bubble_ex3, flush_id3, busy3;
  logic [1:0]  fwd_a3, fwd_b3;
  logic [15:0] stall_cnt3, flush_cnt3;

  obs_t        exp_q[$];
  int          n_run;
  int          n_fail;
  logic [15:0] model_stall_cnt;
  logic [15:0] model_flush_cnt;

  dlx_hazard_ctrl u_dut (
    .clock     (clock),
    .reset     (reset),
    .ir_id     (ir_id),
    .ir_ex     (ir_ex),
    .ir_mem    (ir_mem),
    .ir_wb     (ir_wb),
    .branch_en (branch_en),
    .stall_if  (stall_if),
    .bubble_ex (bubble_ex),
    .flush_id  (flush_id),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .busy      (busy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  dlx_hazard_ctrl #(.LOAD_WAIT(3)) u_dut3 (
    .clock     (clock),
    .reset     (reset),
    .ir_id     (ir_id),
    .ir_ex     (ir_ex),
    .ir_mem    (ir_mem),
    .ir_wb     (ir_wb),
    .branch_en (branch_en),
    .stall_if  (stall_if3),
    .bubble_ex (bubble_ex3),
    .flush_id  (flush_id3),
    .fwd_a     (fwd_a3),
    .fwd_b     (fwd_b3),
    .busy      (busy3),
    .stall_cnt (stall_cnt3),
    .flush_cnt (flush_cnt3)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got time limit reached, want $finish first");
    $fatal(1);
  end

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {6'h00, rs1, rs2, rd, 5'h00, 6'h20};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs1,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs1, rt, imm};
  endfunction

  // Expectation with both instances in RUN (identical outputs, busy low).
  function automatic obs_t exp_run(input logic s, input logic b, input logic f,
                                   input logic [1:0] fa, input logic [1:0] fb);
    obs_t o;
    o = '{stall: s, bubble: b, flush: f, fa: fa, fb: fb, busy: 1'b0,
          stall3: s, bubble3: b, flush3: f, busy3: 1'b0};
    return o;
  endfunction

  function automatic obs_t exp_all(input logic s, input logic b, input logic f,
                                   input logic [1:0] fa, input logic [1:0] fb, input logic bz,
                                   input logic s3, input logic b3, input logic f3,
                                   input logic bz3);
    obs_t o;
    o = '{stall: s, bubble: b, flush: f, fa: fa, fb: fb, busy: bz,
          stall3: s3, bubble3: b3, flush3: f3, busy3: bz3};
    return o;
  endfunction

  function automatic stim_t mk(input logic [31:0] id, input logic [31:0] ex,
                               input logic [31:0] mem, input logic [31:0] wb,
                               input logic br, input logic rst, input obs_t e);
    stim_t s;
    s = '{id: id, ex: ex, mem: mem, wb: wb, br: br, rst: rst, e: e};
    return s;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{stall: stall_if, bubble: bubble_ex, flush: flush_id, fa: fwd_a, fb: fwd_b,
          busy: busy, stall3: stall_if3, bubble3: bubble_ex3, flush3: flush_id3,
          busy3: busy3};
    return o;
  endfunction

  function automatic logic [15:0] cnt_want(input logic [15:0] model);
`ifdef DLX_HAZ_PERF_CNT_EN
    return model;
`else
    return (model & 16'h0);
`endif
  endfunction

  // Drive one cycle of stimulus on the falling edge and queue its expectation.
  task automatic apply(input stim_t s);
    @(negedge clock);
    ir_id     = s.id;
    ir_ex     = s.ex;
    ir_mem    = s.mem;
    ir_wb     = s.wb;
    branch_en = s.br;
    reset     = s.rst;
    exp_q.push_back(s.e);
    if (!s.rst) begin
      model_stall_cnt = 16'h0;
      model_flush_cnt = 16'h0;
    end else begin
      if (s.e.stall && model_stall_cnt != 16'hFFFF) model_stall_cnt = model_stall_cnt + 16'd1;
      if (s.e.flush && model_flush_cnt != 16'hFFFF) model_flush_cnt = model_flush_cnt + 16'd1;
    end
  endtask

  task automatic test_reset();
    stim_t v[$];
    obs_t  got, want;
    v.push_back(mk(NOP, NOP, NOP, NOP, 1'b0, 1'b1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 1'b0, 1'b1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    foreach (v[i]) begin
      apply(v[i]);
      #2;
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %b want %b (stall,bub,flush,fa,fb,busy,stall3,bub3,flush3,busy3)", i, got, want);
      end
    end
    @(negedge clock); #2;
    n_run++;
    if (stall_cnt !== cnt_want(model_stall_cnt) || flush_cnt !== cnt_want(model_flush_cnt)) begin
      n_fail++;
      $display("FAIL reset_cnt: got stall_cnt=%0d flush_cnt=%0d want %0d %0d", stall_cnt, flush_cnt,
               cnt_want(model_stall_cnt), cnt_want(model_flush_cnt));
    end
  endtask

  task automatic test_load_use();
    stim_t v[$];
    obs_t  got, want;
    // Pair held one cycle, then the pipeline advances the load (bubble in EX).
    v.push_back(mk(ADD_435, LW_R3, NOP, NOP, 0, 1, exp_run(1, 1, 0, 2'b00, 2'b00)));
    v.push_back(mk(ADD_435, NOP, LW_R3, NOP, 0, 1, exp_all(0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 1)));
    v.push_back(mk(ADD_435, NOP, NOP, LW_R3, 0, 1, exp_all(0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 1)));
    v.push_back(mk(NOP, ADD_435, NOP, LW_R3, 0, 1, exp_run(0, 0, 0, 2'b10, 2'b00)));
    // Not a hazard: ID writes r3 rather than reading it; load to r0; J ignores [25:21].
    v.push_back(mk(i_type(6'h08, 5'd2, 5'd3, 16'h4), LW_R3, NOP, NOP, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    v.push_back(mk(r_type(5'd4, 5'd0, 5'd5), i_type(6'h23, 5'd1, 5'd0, 16'h0), NOP, NOP, 0, 1,
                   exp_run(0, 0, 0, 2'b00, 2'b00)));
    v.push_back(mk({6'h02, 5'd3, 21'h0}, LW_R3, NOP, NOP, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    // Store reads r3 through its rs2 field: hazard.
    v.push_back(mk(i_type(6'h2B, 5'd1, 5'd3, 16'h0), LW_R3, NOP, NOP, 0, 1, exp_run(1, 1, 0, 2'b00, 2'b00)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 1, exp_all(0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 1)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 1, exp_all(0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 1)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    foreach (v[i]) begin
      apply(v[i]);
      #2;
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %b want %b (stall,bub,flush,fa,fb,busy,stall3,bub3,flush3,busy3)", i, got, want);
      end
    end
    @(negedge clock); #2;
    n_run++;
    if (stall_cnt !== cnt_want(model_stall_cnt) || flush_cnt !== cnt_want(model_flush_cnt)) begin
      n_fail++;
      $display("FAIL load_use_cnt: got stall_cnt=%0d flush_cnt=%0d want %0d %0d", stall_cnt, flush_cnt,
               cnt_want(model_stall_cnt), cnt_want(model_flush_cnt));
    end
  endtask

  task automatic test_forwarding();
    stim_t       v[$];
    obs_t        got, want;
    logic [31:0] add_312, add_567, add_367, lw_r5, sw_r3, sw_53, addi_r3;
    add_312 = r_type(5'd3, 5'd1, 5'd2);
    add_567 = r_type(5'd5, 5'd6, 5'd7);
    add_367 = r_type(5'd3, 5'd6, 5'd7);
    lw_r5   = i_type(6'h23, 5'd1, 5'd5, 16'h0);
    sw_r3   = i_type(6'h2B, 5'd1, 5'd3, 16'h0);
    sw_53   = i_type(6'h2B, 5'd5, 5'd3, 16'h0);
    addi_r3 = i_type(6'h08, 5'd2, 5'd3, 16'h4);
    v.push_back(mk(NOP, ADD_435, add_312, add_567, 0, 1, exp_run(0, 0, 0, 2'b01, 2'b10)));
    v.push_back(mk(NOP, ADD_435, r_type(5'd0, 5'd1, 5'd2), add_567, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b10)));
    v.push_back(mk(NOP, ADD_435, add_312, add_367, 0, 1, exp_run(0, 0, 0, 2'b01, 2'b00)));
    v.push_back(mk(NOP, ADD_435, NOP, add_367, 0, 1, exp_run(0, 0, 0, 2'b10, 2'b00)));
    v.push_back(mk(NOP, ADD_435, LW_R3, NOP, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    v.push_back(mk(NOP, ADD_435, LW_R3, lw_r5, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b10)));
    v.push_back(mk(NOP, ADD_435, sw_r3, NOP, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    v.push_back(mk(NOP, sw_53, add_312, add_567, 0, 1, exp_run(0, 0, 0, 2'b10, 2'b01)));
    v.push_back(mk(NOP, addi_r3, add_312, NOP, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    foreach (v[i]) begin
      apply(v[i]);
      #2;
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL forwarding[%0d]: got %b want %b (stall,bub,flush,fa,fb,busy,stall3,bub3,flush3,busy3)", i, got, want);
      end
    end
  endtask

  task automatic test_branch();
    stim_t v[$];
    obs_t  got, want;
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 0, exp_run(0, 0, 0, 2'b00, 2'b00)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 1, 1, exp_run(0, 1, 1, 2'b00, 2'b00)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 1, exp_all(0, 1, 1, 2'b00, 2'b00, 1, 0, 1, 1, 1)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    foreach (v[i]) begin
      apply(v[i]);
      #2;
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL branch[%0d]: got %b want %b (stall,bub,flush,fa,fb,busy,stall3,bub3,flush3,busy3)", i, got, want);
      end
    end
    @(negedge clock); #2;
    n_run++;
    if (stall_cnt !== cnt_want(model_stall_cnt) || flush_cnt !== cnt_want(model_flush_cnt)) begin
      n_fail++;
      $display("FAIL branch_cnt: got stall_cnt=%0d flush_cnt=%0d want %0d %0d", stall_cnt, flush_cnt,
               cnt_want(model_stall_cnt), cnt_want(model_flush_cnt));
    end
  endtask

  task automatic test_simultaneous();
    stim_t v[$];
    obs_t  got, want;
    // Branch beats load-use; reset during FLUSH aborts it.
    v.push_back(mk(ADD_435, LW_R3, NOP, NOP, 1, 1, exp_run(0, 1, 1, 2'b00, 2'b00)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 0, exp_all(0, 1, 1, 2'b00, 2'b00, 1, 0, 1, 1, 1)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    // Reset during the LOAD_WAIT=3 stall aborts it.
    v.push_back(mk(ADD_435, LW_R3, NOP, NOP, 0, 1, exp_run(1, 1, 0, 2'b00, 2'b00)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 0, exp_all(0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 1)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    // Branch while stalled is ignored by the stalled instance only.
    v.push_back(mk(ADD_435, LW_R3, NOP, NOP, 0, 1, exp_run(1, 1, 0, 2'b00, 2'b00)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 1, 1, exp_all(0, 1, 1, 2'b00, 2'b00, 0, 1, 1, 0, 1)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 1, exp_all(0, 1, 1, 2'b00, 2'b00, 1, 1, 1, 0, 1)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    foreach (v[i]) begin
      apply(v[i]);
      #2;
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL simultaneous[%0d]: got %b want %b (stall,bub,flush,fa,fb,busy,stall3,bub3,flush3,busy3)", i, got, want);
      end
    end
    @(negedge clock); #2;
    n_run++;
    if (stall_cnt !== cnt_want(model_stall_cnt) || flush_cnt !== cnt_want(model_flush_cnt)) begin
      n_fail++;
      $display("FAIL simultaneous_cnt: got stall_cnt=%0d flush_cnt=%0d want %0d %0d", stall_cnt, flush_cnt,
               cnt_want(model_stall_cnt), cnt_want(model_flush_cnt));
    end
  endtask

  task automatic test_back_to_back();
    stim_t v[$];
    obs_t  got, want;
    v.push_back(mk(ADD_435, LW_R3, NOP, NOP, 0, 1, exp_run(1, 1, 0, 2'b00, 2'b00)));
    v.push_back(mk(ADD_435, i_type(6'h23, 5'd1, 5'd5, 16'h0), NOP, NOP, 0, 1,
                   exp_all(1, 1, 0, 2'b00, 2'b00, 0, 1, 1, 0, 1)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 1, exp_all(0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 1)));
    // Second branch while flushing restarts the flush count.
    v.push_back(mk(NOP, NOP, NOP, NOP, 1, 1, exp_run(0, 1, 1, 2'b00, 2'b00)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 1, 1, exp_all(0, 1, 1, 2'b00, 2'b00, 1, 0, 1, 1, 1)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 1, exp_all(0, 1, 1, 2'b00, 2'b00, 1, 0, 1, 1, 1)));
    v.push_back(mk(NOP, NOP, NOP, NOP, 0, 1, exp_run(0, 0, 0, 2'b00, 2'b00)));
    foreach (v[i]) begin
      apply(v[i]);
      #2;
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %b want %b (stall,bub,flush,fa,fb,busy,stall3,bub3,flush3,busy3)", i, got, want);
      end
    end
    @(negedge clock); #2;
    n_run++;
    if (stall_cnt !== cnt_want(model_stall_cnt) || flush_cnt !== cnt_want(model_flush_cnt)) begin
      n_fail++;
      $display("FAIL back_to_back_cnt: got stall_cnt=%0d flush_cnt=%0d want %0d %0d", stall_cnt, flush_cnt,
               cnt_want(model_stall_cnt), cnt_want(model_flush_cnt));
    end
  endtask

`ifdef DLX_HAZ_PERF_CNT_EN
  task automatic test_saturation();
    @(negedge clock);
    ir_id     = ADD_435;
    ir_ex     = LW_R3;
    ir_mem    = NOP;
    ir_wb     = NOP;
    branch_en = 1'b0;
    reset     = 1'b1;
    repeat (70000) @(negedge clock);
    #2;
    n_run++;
    if (stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL saturation: got stall_cnt=%h want ffff", stall_cnt);
    end
    ir_id = NOP;
    ir_ex = NOP;
  endtask
`endif

  initial begin
    clock           = 1'b0;
    reset           = 1'b0;
    ir_id           = NOP;
    ir_ex           = NOP;
    ir_mem          = NOP;
    ir_wb           = NOP;
    branch_en       = 1'b0;
    n_run           = 0;
    n_fail          = 0;
    model_stall_cnt = 16'h0;
    model_flush_cnt = 16'h0;
    repeat (2) @(posedge clock);

    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_simultaneous();
    test_back_to_back();
`ifdef DLX_HAZ_PERF_CNT_EN
    test_saturation();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
